// File: rtl/ysyx_25020037_lsu_axi_master.sv
// AXI4-Lite manager bridging the core's single-outstanding load/store port to AXI.
// Handshake rule on every channel: a transfer happens on a clock edge where valid && ready are both high.
module ysyx_25020037_lsu_axi_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic [ADDR_W-1:0]   araddr,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  state_t state, state_next;
  logic   aw_done, w_done;
  logic   accept, ar_hs, r_hs, aw_hs, w_hs, b_hs, aw_fin, w_fin;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;
  assign ar_hs     = (state == RD_ADDR) & arvalid & arready;
  assign r_hs      = (state == RD_DATA) & rvalid & rready;
  assign aw_hs     = (state == WR_REQ) & awvalid & awready;
  assign w_hs      = (state == WR_REQ) & wvalid & wready;
  assign b_hs      = (state == WR_RESP) & bvalid & bready;
  // A channel counts as finished if it completed earlier or is completing now.
  assign aw_fin    = aw_done | aw_hs;
  assign w_fin     = w_done | w_hs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = req_wen ? WR_REQ : RD_ADDR;
      RD_ADDR: if (ar_hs) state_next = RD_DATA;
      RD_DATA: if (r_hs) state_next = IDLE;
      WR_REQ:  if (aw_fin && w_fin) state_next = WR_RESP;
      WR_RESP: if (b_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      araddr     <= '0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      awaddr     <= '0;
      awvalid    <= 1'b0;
      wdata      <= '0;
      wstrb      <= '0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (req_wen) begin
              awaddr  <= req_addr;
              wdata   <= req_wdata;
              wstrb   <= req_wstrb;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              aw_done <= 1'b0;
              w_done  <= 1'b0;
            end else begin
              araddr  <= req_addr;
              arvalid <= 1'b1;
            end
          end
        end
        RD_ADDR: begin
          if (ar_hs) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
          end
        end
        RD_DATA: begin
          if (r_hs) begin
            rready     <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= rdata;
            resp_err   <= |rresp;
          end
        end
        WR_REQ: begin
          if (aw_hs) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            bready  <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end
        end
        WR_RESP: begin
          // resp_rdata keeps the last read value on write responses.
          if (b_hs) begin
            bready     <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= |bresp;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25020037_lsu_axi_master.sv
// Directed bench for the LSU AXI4-Lite manager: reads, writes, stalls, back-to-back and async reset.
module tb_ysyx_25020037_lsu_axi_master;

  logic        clk, rst;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  rresp, bresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  int pass_cnt  = 0;
  int total_cnt = 0;

  ysyx_25020037_lsu_axi_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  // Driver tasks: inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_req(input logic wen, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] ws);
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wd;
    req_wstrb = ws;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
  endtask

  task automatic test_reset();
    total_cnt++;
    if ({req_ready, arvalid, rready, awvalid, wvalid, bready, resp_valid, resp_err} !== 8'b1000_0000)
      $display("FAIL reset_ctrl: got %b exp 10000000",
               {req_ready, arvalid, rready, awvalid, wvalid, bready, resp_valid, resp_err});
    else pass_cnt++;
    total_cnt++;
    if ({araddr, awaddr, wdata, wstrb, resp_rdata} !== '0)
      $display("FAIL reset_data: got %h %h %h %h %h exp all zero", araddr, awaddr, wdata, wstrb, resp_rdata);
    else pass_cnt++;
  endtask

  task automatic test_read_zero_wait();
    drive_req(1'b0, 32'ha000_0048, '0, '0);
    arready = 1'b1;
    tick();  // one cycle after accept
    total_cnt++;
    if ({arvalid, req_ready, araddr} !== {1'b1, 1'b0, 32'ha000_0048})
      $display("FAIL rd_ar: got v=%b rr=%b a=%h exp v=1 rr=0 a=a0000048", arvalid, req_ready, araddr);
    else pass_cnt++;
    req_valid = 1'b0;
    tick();
    total_cnt++;
    if ({arvalid, rready} !== 2'b01)
      $display("FAIL rd_rready: got %b exp 01", {arvalid, rready});
    else pass_cnt++;
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b00;
    tick();  // three cycles after accept
    total_cnt++;
    if ({resp_valid, resp_err, rready, req_ready, resp_rdata} !== {4'b1001, 32'h1234_5678})
      $display("FAIL rd_resp: got v=%b e=%b rr=%b q=%b d=%h exp 1 0 0 1 12345678",
               resp_valid, resp_err, rready, req_ready, resp_rdata);
    else pass_cnt++;
    rvalid = 1'b0;
    tick();
    total_cnt++;
    if (resp_valid !== 1'b0) $display("FAIL rd_pulse: got %b exp 0", resp_valid);
    else pass_cnt++;
  endtask

  task automatic test_write_w_delay();
    drive_req(1'b1, 32'ha000_03f8, 32'hdead_beef, 4'hf);
    awready = 1'b1; wready = 1'b0;
    tick();
    total_cnt++;
    if ({awvalid, wvalid, awaddr, wdata, wstrb} !== {2'b11, 32'ha000_03f8, 32'hdead_beef, 4'hf})
      $display("FAIL wr_issue: got %b%b %h %h %h exp 11 a00003f8 deadbeef f",
               awvalid, wvalid, awaddr, wdata, wstrb);
    else pass_cnt++;
    req_valid = 1'b0;
    tick();
    awready = 1'b0;
    total_cnt++;
    if ({awvalid, wvalid, bready} !== 3'b010)
      $display("FAIL wr_aw_drop: got %b exp 010", {awvalid, wvalid, bready});
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if ({awvalid, wvalid, bready, wdata, wstrb} !== {3'b010, 32'hdead_beef, 4'hf})
        $display("FAIL wr_w_hold: got %b %h %h exp 010 deadbeef f", {awvalid, wvalid, bready}, wdata, wstrb);
      else pass_cnt++;
    end
    wready = 1'b1;  // four cycles after the AW handshake
    tick();
    wready = 1'b0;
    total_cnt++;
    if ({wvalid, bready} !== 2'b01)
      $display("FAIL wr_bready: got %b exp 01", {wvalid, bready});
    else pass_cnt++;
    bvalid = 1'b1; bresp = 2'b00;
    tick();
    bvalid = 1'b0;
    total_cnt++;
    if ({resp_valid, resp_err, bready, resp_rdata} !== {3'b100, 32'h1234_5678})
      $display("FAIL wr_resp: got %b %h exp 100 12345678", {resp_valid, resp_err, bready}, resp_rdata);
    else pass_cnt++;
  endtask

  task automatic test_write_same_cycle();
    drive_req(1'b1, 32'h1000_0000, 32'h0000_00a5, 4'b0001);
    awready = 1'b1; wready = 1'b1;
    tick();
    req_valid = 1'b0;
    total_cnt++;
    if ({awvalid, wvalid} !== 2'b11)
      $display("FAIL ws_issue: got %b exp 11", {awvalid, wvalid});
    else pass_cnt++;
    tick();
    awready = 1'b0; wready = 1'b0;
    total_cnt++;
    if ({awvalid, wvalid, bready} !== 3'b001)
      $display("FAIL ws_wr_resp: got %b exp 001", {awvalid, wvalid, bready});
    else pass_cnt++;
    bvalid = 1'b1; bresp = 2'b10;
    tick();
    bvalid = 1'b0; bresp = 2'b00;
    total_cnt++;
    if ({resp_valid, resp_err, resp_rdata} !== {2'b11, 32'h1234_5678})
      $display("FAIL ws_resp: got %b %h exp 11 12345678", {resp_valid, resp_err}, resp_rdata);
    else pass_cnt++;
  endtask

  task automatic test_read_stall();
    drive_req(1'b0, 32'h0200_0004, '0, '0);
    arready = 1'b0;
    tick();
    // Garbage request while busy must be ignored.
    drive_req(1'b1, 32'hffff_ffff, 32'h0bad_0bad, 4'h3);
    for (int i = 0; i < 10; i++) begin
      total_cnt++;
      if ({arvalid, req_ready, awvalid, araddr} !== {3'b100, 32'h0200_0004})
        $display("FAIL stall_hold: got %b %h exp 100 02000004", {arvalid, req_ready, awvalid}, araddr);
      else pass_cnt++;
      if (i < 9) tick();
    end
    req_valid = 1'b0;
    arready = 1'b1;
    tick();
    arready = 1'b0;
    total_cnt++;
    if ({arvalid, rready} !== 2'b01)
      $display("FAIL stall_rready: got %b exp 01", {arvalid, rready});
    else pass_cnt++;
    rvalid = 1'b1; rdata = 32'hcafe_f00d; rresp = 2'b11;
    tick();
    rvalid = 1'b0; rresp = 2'b00;
    total_cnt++;
    if ({resp_valid, resp_err, resp_rdata} !== {2'b11, 32'hcafe_f00d})
      $display("FAIL stall_resp: got %b %h exp 11 cafef00d", {resp_valid, resp_err}, resp_rdata);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({resp_valid, req_ready, awvalid, arvalid} !== 4'b0100)
      $display("FAIL stall_ignored: got %b exp 0100", {resp_valid, req_ready, awvalid, arvalid});
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    // Always-ready subordinate; data changes between the two reads.
    arready = 1'b1; awready = 1'b1; wready = 1'b1;
    rvalid = 1'b1; bvalid = 1'b1; rresp = 2'b00; bresp = 2'b00;
    rdata = 32'h1111_1111;
    drive_req(1'b0, 32'h0000_0100, '0, '0);
    tick();
    total_cnt++;
    if ({arvalid, araddr} !== {1'b1, 32'h0000_0100})
      $display("FAIL b2b_ar1: got %b %h exp 1 00000100", arvalid, araddr);
    else pass_cnt++;
    drive_req(1'b1, 32'h0000_0104, 32'h55aa_55aa, 4'hc);
    tick();
    tick();
    total_cnt++;
    if ({resp_valid, req_ready, resp_err, resp_rdata} !== {3'b110, 32'h1111_1111})
      $display("FAIL b2b_resp1: got %b %h exp 110 11111111", {resp_valid, req_ready, resp_err}, resp_rdata);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({resp_valid, awvalid, wvalid, awaddr, wdata, wstrb} !== {3'b011, 32'h0000_0104, 32'h55aa_55aa, 4'hc})
      $display("FAIL b2b_wr: got %b %h %h %h exp 011 00000104 55aa55aa c",
               {resp_valid, awvalid, wvalid}, awaddr, wdata, wstrb);
    else pass_cnt++;
    drive_req(1'b0, 32'h0000_0108, '0, '0);
    rdata = 32'h2222_2222;
    tick();
    tick();
    total_cnt++;
    if ({resp_valid, req_ready, resp_err, resp_rdata} !== {3'b110, 32'h1111_1111})
      $display("FAIL b2b_resp2: got %b %h exp 110 11111111", {resp_valid, req_ready, resp_err}, resp_rdata);
    else pass_cnt++;
    tick();
    req_valid = 1'b0;
    total_cnt++;
    if ({arvalid, araddr} !== {1'b1, 32'h0000_0108})
      $display("FAIL b2b_ar3: got %b %h exp 1 00000108", arvalid, araddr);
    else pass_cnt++;
    tick();
    tick();
    total_cnt++;
    if ({resp_valid, resp_err, resp_rdata} !== {2'b10, 32'h2222_2222})
      $display("FAIL b2b_resp3: got %b %h exp 10 22222222", {resp_valid, resp_err}, resp_rdata);
    else pass_cnt++;
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_write();
    drive_req(1'b1, 32'h0000_0020, 32'h1357_9bdf, 4'hf);
    tick();
    req_valid = 1'b0;
    total_cnt++;
    if ({awvalid, wvalid, req_ready} !== 3'b110)
      $display("FAIL rstw_pre: got %b exp 110", {awvalid, wvalid, req_ready});
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if ({awvalid, wvalid, bready, arvalid, rready, req_ready, awaddr} !== {6'b000001, 32'h0})
      $display("FAIL rstw_async: got %b %h exp 000001 00000000",
               {awvalid, wvalid, bready, arvalid, rready, req_ready}, awaddr);
    else pass_cnt++;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total_cnt++;
      if ({resp_valid, req_ready, awvalid, wvalid} !== 4'b0100)
        $display("FAIL rstw_quiet: got %b exp 0100", {resp_valid, req_ready, awvalid, wvalid});
      else pass_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick();
    test_reset();
    tick();
    rst = 1'b0;
    tick();
    test_read_zero_wait();
    test_write_w_delay();
    test_write_same_cycle();
    test_read_stall();
    test_back_to_back();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
